// File: rtl/sar_conversion_controller_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR conversion controller:
//   sar_ctrl_state_t : controller state encoding
//   N_BITS           : default converter resolution
//   SAR_CYCLES       : clocks the SAR needs for one conversion at N_BITS
//   counter_width()  : width of a counter that must hold max(a, b)
// ---------------------------------------------------------------------------
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_FAULT   = 2'd3
  } sar_ctrl_state_t;

  localparam int N_BITS     = 10;
  localparam int SAR_CYCLES = 2 * N_BITS;

  // One counter serves both the sample phase and the watchdog, so it must
  // be wide enough for whichever phase is longer.
  function automatic int counter_width(input int sample_cycles, input int sar_cycles);
    int longest;
    longest = (sample_cycles > sar_cycles) ? sample_cycles : sar_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sar_conversion_controller_if.sv
// ---------------------------------------------------------------------------
// sar_conversion_controller_if
// Valid/ready result stream leaving the conversion controller.
//   result_data  : captured conversion code
//   result_valid : result_data holds an unconsumed result
//   result_ready : consumer accepts the result
// master = producer (controller), slave = consumer.
// ---------------------------------------------------------------------------
interface sar_conversion_controller_if #(
  parameter int N_BITS = sar_pkg::N_BITS
);
  logic [N_BITS-1:0] result_data;
  logic              result_valid;
  logic              result_ready;

  modport master (output result_data, output result_valid, input result_ready);
  modport slave  (input result_data, input result_valid, output result_ready);
endinterface

// File: rtl/sar_result_holding_register.sv
// ---------------------------------------------------------------------------
// sar_result_holding_register
// Single-entry valid/ready output register with overwrite and overrun.
//   clk, reset     : clock, asynchronous active-low reset
//   capture        : load capture_data this cycle
//   capture_data   : new result
//   ready          : consumer accepts (transfer when valid && ready)
//   clear_overrun  : synchronous clear of the sticky overrun flag
//   data, valid    : held result and its valid flag
//   overrun        : sticky, an unconsumed result was overwritten
// ---------------------------------------------------------------------------
module sar_result_holding_register #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             transfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    transfer     = valid_reg && ready;
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (transfer) valid_next = 1'b0;
    // A capture on the transfer cycle refills the slot without loss.
    if (capture) begin
      valid_next = 1'b1;
      data_next  = capture_data;
    end
    if (clear_overrun) overrun_next = 1'b0;
    // Set is evaluated after clear so a simultaneous overrun wins.
    if (capture && valid_reg && !transfer) overrun_next = 1'b1;
  end

  assign data    = data_reg;
  assign valid   = valid_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/sar_conversion_controller.sv
// ---------------------------------------------------------------------------
// sar_conversion_controller
// Owns a SAR conversion: start -> timed sample phase -> SAR enable for one
// full SAR cycle -> result capture, with a watchdog on end-of-conversion.
//   clk, reset          : clock, asynchronous active-low reset
//   start, continuous   : conversion request / back-to-back mode
//   sample              : track/hold control (sample phase)
//   conduct_comparison  : SAR enable (convert phase)
//   eoc                 : SAR end-of-conversion
//   quantized_voltage   : SAR code; bit 0 is still the trial bit at eoc
//   feedback_value      : comparator decision (the real LSB at eoc)
//   busy                : controller not idle
//   overrun, clear_overrun : sticky overwrite flag and its clear
//   fault               : sticky watchdog error, cleared by reset only
//   res                 : result valid/ready stream (master)
// ---------------------------------------------------------------------------
module sar_conversion_controller #(
  parameter int N_BITS        = sar_pkg::N_BITS,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         continuous,
  output logic                         sample,
  output logic                         conduct_comparison,
  input  logic                         eoc,
  input  logic [N_BITS-1:0]            quantized_voltage,
  input  logic                         feedback_value,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         clear_overrun,
  output logic                         fault,
  sar_conversion_controller_if.master  res
);
  import sar_pkg::*;

  localparam int SAR_LEN = 2 * N_BITS;
  localparam int CW      = counter_width(SAMPLE_CYCLES, SAR_LEN);

  sar_ctrl_state_t   state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              capture;
  logic [N_BITS-1:0] capture_data;
  logic              unused_trial_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // count_reg is the sample-phase counter in SAMPLE and the watchdog in
  // CONVERT; it is zeroed on every phase entry.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SAMPLE;
          count_next = '0;
        end
      end
      ST_SAMPLE: begin
        if (count_reg == CW'(SAMPLE_CYCLES - 1)) begin
          state_next = ST_CONVERT;
          count_next = '0;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      ST_CONVERT: begin
        // No abort path: only eoc or the watchdog leave this state.
        if (eoc) begin
          capture    = 1'b1;
          count_next = '0;
          state_next = continuous ? ST_SAMPLE : ST_IDLE;
        end else if (count_reg == CW'(SAR_LEN - 1)) begin
          state_next = ST_FAULT;
          count_next = '0;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // Controls are pure decodes of the state register.
  assign sample             = (state_reg == ST_SAMPLE);
  assign conduct_comparison = (state_reg == ST_CONVERT);
  assign busy               = (state_reg != ST_IDLE);
  assign fault              = (state_reg == ST_FAULT);

  // At eoc the SAR still shows its trial bit in the LSB; the comparator
  // decision for that bit is feedback_value.
  assign capture_data     = {quantized_voltage[N_BITS-1:1], feedback_value};
  assign unused_trial_bit = quantized_voltage[0];

  sar_result_holding_register #(
    .WIDTH (N_BITS)
  ) u_hold (
    .clk           (clk),
    .reset         (reset),
    .capture       (capture),
    .capture_data  (capture_data),
    .ready         (res.result_ready),
    .clear_overrun (clear_overrun),
    .data          (res.result_data),
    .valid         (res.result_valid),
    .overrun       (overrun)
  );

endmodule
